// File: rtl/prefix_chain_pkg.sv
// Shared operator codes and bit-level helpers for the prefix chain pipeline.
// Reserved op 2'b11 falls through to AND everywhere.
package prefix_chain_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    function automatic logic identity(input logic [1:0] op);
        case (op)
            OP_OR:   identity = 1'b0;
            OP_XOR:  identity = 1'b0;
            default: identity = 1'b1;
        endcase
    endfunction

    function automatic logic apply(
        input logic [1:0] op,
        input logic       a,
        input logic       b
    );
        case (op)
            OP_OR:   apply = a | b;
            OP_XOR:  apply = a ^ b;
            default: apply = a & b;
        endcase
    endfunction

endpackage

// File: rtl/prefix_ripple.sv
// Combinational ripple prefix: prefix[i] = seed op d[0] op ... op d[i].
module prefix_ripple
    import prefix_chain_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             seed,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] prefix
);

    logic acc;

    always_comb begin
        acc    = seed;
        prefix = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc       = apply(op, acc, data[i]);
            prefix[i] = acc;
        end
    end

endmodule

// File: rtl/prefix_chain_pipe.sv
// Two-stage valid/ready prefix-reduction pipeline with cross-beat carry.
// Stage 1 latches operands and seed; stage 2 ripples and registers the result.
module prefix_chain_pipe
    import prefix_chain_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OP_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_chain,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_prefix,
    output logic             out_last
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic             s1_seed;
    logic [OP_W-1:0]  s1_op;
    logic             s1_last;
    logic             s2_valid;

    logic             sof;
    logic             carry;
    logic [OP_W-1:0]  op_q;

    logic             adv1;
    logic             adv2;
    logic             accept;
    logic [OP_W-1:0]  eff_op;
    logic             seed;
    logic             red;
    logic [WIDTH-1:0] ripple;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    assign eff_op = sof ? in_op : op_q;
    assign seed   = (in_chain && !sof) ? carry : identity(eff_op);

    // Full-word reduction feeds the carry directly, so the next beat
    // never has to wait for stage 2.
    always_comb begin
        red = seed;
        for (int i = 0; i < WIDTH; i++) begin
            red = apply(eff_op, red, in_data[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sof   <= 1'b1;
            carry <= 1'b0;
            op_q  <= '0;
        end else if (accept) begin
            sof   <= in_last;
            carry <= red;
            if (sof) begin
                op_q <= in_op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_seed  <= 1'b0;
            s1_op    <= '0;
            s1_last  <= 1'b0;
        end else if (adv1) begin
            s1_valid <= accept;
            s1_data  <= in_data;
            s1_seed  <= seed;
            s1_op    <= eff_op;
            s1_last  <= in_last;
        end
    end

    prefix_ripple #(
        .WIDTH (WIDTH)
    ) u_ripple (
        .seed   (s1_seed),
        .op     (s1_op),
        .data   (s1_data),
        .prefix (ripple)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_prefix <= '0;
            out_last   <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_prefix <= ripple;
                out_last   <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_prefix_chain_pipe.sv
// Scoreboard bench for prefix_chain_pipe at WIDTH=4.
module tb_prefix_chain_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [1:0]   in_op = 2'b00;
    logic         in_chain = 1'b0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_prefix;
    logic         out_last;

    int total = 0;
    int bad = 0;

    logic [W:0] exp_q[$];
    logic [W:0] rcv_q[$];
    logic       acc_flag;

    logic       m_sof = 1'b1;
    logic       m_carry = 1'b0;
    logic [1:0] m_op = 2'b00;

    always #5 clk = ~clk;

    prefix_chain_pipe #(.WIDTH(W), .OP_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_op      (in_op),
        .in_chain   (in_chain),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_prefix (out_prefix),
        .out_last   (out_last)
    );

    function automatic logic [W-1:0] ref_prefix(
        input logic [1:0] op, input logic s, input logic [W-1:0] d);
        logic a;
        logic [W-1:0] p;
        a = s;
        p = '0;
        for (int i = 0; i < W; i++) begin
            if (op == 2'b01) a = a | d[i];
            else if (op == 2'b10) a = a ^ d[i];
            else a = a & d[i];
            p[i] = a;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_sof = 1'b1;
        m_carry = 1'b0;
        m_op = 2'b00;
        exp_q.delete();
        rcv_q.delete();
    endtask

    // One clock: record accepts into the model and output fires into rcv_q.
    task automatic tick();
        logic [1:0] eop;
        logic s;
        logic [W-1:0] p;
        #1;
        acc_flag = in_valid && in_ready;
        if (acc_flag) begin
            eop = m_sof ? in_op : m_op;
            if (m_sof) m_op = in_op;
            if (in_chain && !m_sof) s = m_carry;
            else s = (eop == 2'b01 || eop == 2'b10) ? 1'b0 : 1'b1;
            p = ref_prefix(eop, s, in_data);
            exp_q.push_back({in_last, p});
            m_carry = p[W-1];
            m_sof = in_last;
        end
        if (out_valid && out_ready) rcv_q.push_back({out_last, out_prefix});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [W-1:0] d, input logic [1:0] op,
                         input logic ch, input logic last);
        in_valid = 1'b1;
        in_data = d;
        in_op = op;
        in_chain = ch;
        in_last = last;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] op,
                        input logic ch, input logic last);
        int n;
        drive(d, op, ch, last);
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc_flag && n < 50);
        in_valid = 1'b0;
        total++;
        if (!acc_flag) begin
            bad++;
            $display("FAIL send_timeout got=not_accepted want=accepted");
        end
    endtask

    task automatic drain(input int want_n);
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (rcv_q.size() < want_n && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (rcv_q.size() < want_n) begin
            bad++;
            $display("FAIL drain_timeout got=%0d want=%0d", rcv_q.size(), want_n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total += 4;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid);
        end
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready);
        end
        if (out_prefix !== 4'b0000) begin
            bad++; $display("FAIL rst_prefix got=%b want=0000", out_prefix);
        end
        if (out_last !== 1'b0) begin
            bad++; $display("FAIL rst_last got=%b want=0", out_last);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(4'b1101, 2'b00, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        total += 4;
        if (acc_flag !== 1'b1) begin
            bad++; $display("FAIL single_accept got=%b want=1", acc_flag);
        end
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL single_lat1 got=%b want=0", out_valid);
        end
        tick();
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL single_lat2 got=%b want=1", out_valid);
        end
        if ({out_last, out_prefix} !== 5'b1_0001) begin
            bad++;
            $display("FAIL single_value got=%b want=10001", {out_last, out_prefix});
        end
        drain(1);
        model_reset();
    endtask

    task automatic test_ops();
        logic [W:0] want[$];
        logic [W:0] got;
        want = '{5'b1_1100, 5'b1_0010, 5'b1_1111};
        send(4'b0100, 2'b01, 1'b0, 1'b1);
        send(4'b0110, 2'b10, 1'b0, 1'b1);
        send(4'b1111, 2'b11, 1'b0, 1'b1);
        drain(3);
        for (int i = 0; i < 3 && rcv_q.size() > 0; i++) begin
            got = rcv_q.pop_front();
            total++;
            if (got !== want[i]) begin
                bad++; $display("FAIL ops_%0d got=%b want=%b", i, got, want[i]);
            end
        end
        model_reset();
    endtask

    task automatic test_chain();
        logic [W:0] want[$];
        logic [W:0] got;
        want = '{5'b0_0111, 5'b1_0000, 5'b0_0111, 5'b1_1111,
                 5'b0_0111, 5'b1_0000};
        send(4'b0111, 2'b00, 1'b0, 1'b0);
        send(4'b1111, 2'b00, 1'b1, 1'b1);
        send(4'b0111, 2'b00, 1'b0, 1'b0);
        send(4'b1111, 2'b00, 1'b0, 1'b1);
        send(4'b0111, 2'b00, 1'b0, 1'b0);
        send(4'b1111, 2'b01, 1'b1, 1'b1);
        drain(6);
        for (int i = 0; i < 6 && rcv_q.size() > 0; i++) begin
            got = rcv_q.pop_front();
            total++;
            if (got !== want[i]) begin
                bad++; $display("FAIL chain_%0d got=%b want=%b", i, got, want[i]);
            end
        end
        model_reset();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d[4];
        logic [W-1:0] hold;
        logic [W:0] got;
        logic [W:0] exp;
        int acc_n;
        d = '{4'b1111, 4'b1011, 4'b0111, 4'b1110};
        out_ready = 1'b0;
        acc_n = 0;
        hold = '0;
        for (int i = 0; i < 4; i++) begin
            drive(d[i], 2'b00, 1'b0, 1'b1);
            if (i == 3) hold = out_prefix;
            tick();
            if (acc_flag) acc_n++;
        end
        total += 3;
        if (acc_n != 2) begin
            bad++; $display("FAIL bp_accepts got=%0d want=2", acc_n);
        end
        #1;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready);
        end
        if (out_prefix !== hold) begin
            bad++; $display("FAIL bp_hold got=%b want=%b", out_prefix, hold);
        end
        out_ready = 1'b1;
        for (int i = acc_n; i < 4; i++) send(d[i], 2'b00, 1'b0, 1'b1);
        drain(4);
        total++;
        if (exp_q.size() != 4) begin
            bad++; $display("FAIL bp_count got=%0d want=4", exp_q.size());
        end
        while (rcv_q.size() > 0 && exp_q.size() > 0) begin
            got = rcv_q.pop_front();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL bp_order got=%b want=%b", got, exp);
            end
        end
        model_reset();
    endtask

    task automatic test_stream();
        logic [W:0] got;
        logic [W:0] exp;
        int n;
        int sent;
        sent = 0;
        n = 0;
        while (sent < 100 && n < 2000) begin
            drive(W'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (out_ready) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++; $display("FAIL stream_bubble got=%b want=1", in_ready);
                end
            end
            tick();
            if (acc_flag) sent++;
            n++;
        end
        in_valid = 1'b0;
        drain(exp_q.size());
        total++;
        if (rcv_q.size() != exp_q.size() || sent != 100) begin
            bad++;
            $display("FAIL stream_count got=%0d want=%0d", rcv_q.size(), exp_q.size());
        end
        while (rcv_q.size() > 0 && exp_q.size() > 0) begin
            got = rcv_q.pop_front();
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL stream_beat got=%b want=%b", got, exp);
            end
        end
        model_reset();
    endtask

    task automatic test_reset_mid();
        logic [W:0] got;
        out_ready = 1'b0;
        send(4'b0011, 2'b01, 1'b0, 1'b0);
        send(4'b0101, 2'b01, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_valid got=%b want=0", out_valid);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        send(4'b0001, 2'b10, 1'b1, 1'b1);
        drain(1);
        total++;
        got = (rcv_q.size() > 0) ? rcv_q.pop_front() : '0;
        if (got !== 5'b1_1111) begin
            bad++; $display("FAIL rstmid_value got=%b want=11111", got);
        end
        model_reset();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_ops();
        test_chain();
        test_backpressure();
        test_stream();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prefix_chain_pipe.md
Name: prefix_chain_pipe

Overview:
Parametrised, pipelined successor to the team's fixed 4-input cascaded-AND gate chain. Each accepted beat produces the full prefix-reduction vector of the input word. The reduction operator is selectable: AND, OR or XOR. Prefixes can optionally be chained across multi-beat frames through a carry register. Sits between a valid/ready producer and consumer; fully throughput-1 with backpressure.

Parameters:
WIDTH, 4, number of input bits and prefix outputs; legal range 2..64.
OP_W, 2, width of the operator select; fixed, kept only for readability.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_data  input  WIDTH  operand bits; bit 0 is the chain head
in_op  input  2  00 AND, 01 OR, 10 XOR, 11 reserved (treated as AND)
in_chain  input  1  seed this beat with the carry from the previous beat of the same frame
in_last  input  1  final beat of the frame
out_valid  output  1  out_prefix valid
out_ready  input  1  consumer accepts the output beat
out_prefix  output  WIDTH  prefix[i] = seed op d[0] op ... op d[i]
out_last  output  1  in_last of the corresponding beat

Behaviour:
- Reset (async assert, sync release on the clock edge):
  - s1_valid, s2_valid, out_valid = 0.
  - out_prefix = 0, out_last = 0.
  - sof = 1, carry = 0, op_q = 00.
- Accept: a beat is accepted when in_valid && in_ready.
- Handshake:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1.
  - in_ready has a combinational path from out_ready; no skid buffer is used.
- Operator:
  - eff_op = sof ? in_op : op_q.
  - On an accept with sof=1, op_q <= in_op.
  - in_op on non-first beats of a frame is ignored.
- Identity value: AND → 1, OR → 0, XOR → 0.
- Seed: seed = (in_chain && !sof) ? carry : identity(eff_op).
  - in_chain=1 on the first beat of a frame still uses the identity.
- Carry: on accept, carry <= seed eff_op (reduction of in_data over all WIDTH bits). This is computed combinationally at the input, so there is no hazard against the stage-2 result.
- Start of frame: on accept, sof <= in_last.
- Stage 1: on adv1, captures {in_valid&&in_ready, in_data, seed, eff_op, in_last}.
- Stage 2: on adv2, computes the ripple prefix from the stage-1 contents and registers it to out_prefix/out_last. out_valid = s2_valid.
- Latency: exactly 2 cycles from accept to out_valid when out_ready=1. Sustained throughput is 1 beat/cycle.
- Backpressure:
  - While out_ready=0 with both stages full, in_ready=0.
  - Outputs hold stable while out_valid && !out_ready.
  - Beats are never dropped, duplicated or reordered.
- Simultaneous events: a stage may fill and drain in the same cycle. Carry/sof update and stage-1 capture happen on the same edge.
- Reset mid-frame: pending beats are discarded, and the next beat starts a new frame (identity seed, fresh op).
- The reserved op 11 is decoded exactly as AND, including the identity value.

Decomposition:
- Shared package prefix_chain_pkg:
  - op codes OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10.
  - function identity(op).
  - function apply(op, a, b).
- One natural sub-module: prefix_ripple (combinational, parameter WIDTH; inputs seed, op, data; output prefix). Instantiated in stage 2.
- Reduction for the carry reuses apply() in a loop; no second sub-module.

Test Plan:
- AND, WIDTH=4, single beat in_data=4'b1101, in_last=1, out_ready=1 → out_prefix=4'b0001, out_last=1, out_valid exactly 2 cycles after accept.
- OR in_data=4'b0100 → 4'b1100. XOR in_data=4'b0110 → 4'b0010. op 11 with 4'b1111 → 4'b1111.
- Chained AND frame: beat0 4'b0111 (in_chain=0), beat1 4'b1111 (in_chain=1, in_last=1) → 4'b0111, then 4'b0000. Repeating with in_chain=0 on beat1 → 4'b1111. A beat1 with in_op=01 is still reduced as AND.
- Backpressure: hold out_ready=0, offer 4 consecutive beats → exactly 2 accepted and in_ready=0 from then on. Release out_ready → all beats emerge in order with correct values and none lost.
- Streaming: 100 random beats with random op/chain/last and random out_ready → match against a scoreboard model; zero-bubble throughput whenever out_ready=1.
- Assert rst_n mid-frame with both stages full → out_valid=0 immediately. After release, a beat with in_chain=1, XOR, 4'b0001 → 4'b1111 (identity seed, new op).
